// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: four byte reads on a shared byte memory assembled into a little-endian word.
// Loader has priority in IDLE. Build option IMEM_ALIGN_CHECK_EN also rejects unaligned fetch addresses.
module imem_fetch_ctrl #(
  parameter int MEM_BYTES = 400,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, LAST, RESP} state_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       asm_q;
  logic              err_q;
  logic              accept;
  logic              range_bad;
  logic              align_bad;
  logic              load_ok;
  logic [ADDR_W:0]   end_addr;

  // One extra bit so a request near the top of the address space cannot wrap into range.
  assign end_addr  = {1'b0, fetch_addr} + (ADDR_W+1)'(3);
  assign range_bad = (end_addr >= LIMIT);
  assign load_ok   = ({1'b0, load_addr} < LIMIT);

`ifdef IMEM_ALIGN_CHECK_EN
  assign align_bad = (fetch_addr[1:0] != 2'b00);
`else
  assign align_bad = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    fetch_ready = 1'b0;
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
    fetch_data  = 32'h0;
    load_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 8'h0;
    case (state)
      IDLE: begin
        if (load_req) begin
          load_ack = 1'b1;
          if (load_ok) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = load_addr;
            mem_wdata = load_data;
          end
        end else begin
          fetch_ready = 1'b1;
          if (fetch_req) begin
            accept    = 1'b1;
            state_nxt = (range_bad || align_bad) ? RESP : RD;
          end
        end
      end
      RD: begin
        mem_en   = 1'b1;
        mem_addr = base + ADDR_W'(cnt);
        if (cnt == 2'd3) state_nxt = LAST;
      end
      LAST: state_nxt = RESP;
      RESP: begin
        fetch_valid = 1'b1;
        fetch_err   = err_q;
        fetch_data  = err_q ? 32'h0 : asm_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      base  <= '0;
      asm_q <= 32'h0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            base  <= fetch_addr;
            err_q <= range_bad || align_bad;
            cnt   <= 2'd0;
          end
        end
        RD: begin
          cnt <= cnt + 2'd1;
          // Read data lags the issue by one cycle, so it lands in the previous lane.
          if (cnt != 2'd0) asm_q[{cnt - 2'd1, 3'b000} +: 8] <= mem_rdata;
        end
        LAST: asm_q[31:24] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule
